// File: rtl/line_serializer.sv
// Cache line serializer: one 256-bit line in, eight 32-bit words out over valid/ready.
// Define LINE_SERIALIZER_CWF_EN for critical-word-first ordering starting at start_word.
module line_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] line_in,
  input  logic         line_valid,
  output logic         line_ready,
  input  logic [2:0]   start_word,
  output logic [31:0]  word_out,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [2:0]   word_idx,
  output logic         word_last,
  output logic         busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q [8];
  logic [31:0] buf_d [8];
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  start_idx_s;

`ifdef LINE_SERIALIZER_CWF_EN
  assign start_idx_s = start_word;
`else
  logic unused_start_s;
  assign unused_start_s = ^start_word;
  assign start_idx_s    = 3'd0;
`endif

  // Next-state logic: capture on line handshake, advance on word handshake.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (line_valid) begin
          for (int i = 0; i < 8; i++) begin
            buf_d[i] = line_in[i*32 +: 32];
          end
          cnt_d   = 3'd0;
          idx_d   = start_idx_s;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (word_ready) begin
          if (cnt_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            idx_d = idx_q + 3'd1;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; line_ready is also held low during reset.
  always_comb begin
    line_ready = 1'b0;
    word_valid = 1'b0;
    word_out   = 32'd0;
    word_idx   = 3'd0;
    word_last  = 1'b0;
    busy       = 1'b0;
    if (state_q == SEND) begin
      word_valid = 1'b1;
      busy       = 1'b1;
      word_out   = buf_q[idx_q];
      word_idx   = idx_q;
      word_last  = (cnt_q == 3'd7);
    end else begin
      line_ready = ~rst;
    end
  end

  // State register with asynchronous reset that discards any partial burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 8; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_line_serializer.sv
// Self-checking bench for line_serializer: directed bursts plus randomized round trips.
module tb_line_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_in;
  logic         line_valid;
  logic         line_ready;
  logic [2:0]   start_word;
  logic [31:0]  word_out;
  logic         word_valid;
  logic         word_ready;
  logic [2:0]   word_idx;
  logic         word_last;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  line_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .start_word (start_word),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_idx   (word_idx),
    .word_last  (word_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Expected order of line indices: critical word first when enabled, else 0..7.
  function automatic logic [2:0] exp_idx(input logic [2:0] sw, input int k);
    int base;
`ifdef LINE_SERIALIZER_CWF_EN
    base = int'(sw);
`else
    base = 0;
`endif
    return 3'((base + k) % 8);
  endfunction

  // Called and returns just after a falling edge. mode: 0 ready always, 1 pattern 1,0,0, 2 random.
  task automatic do_line(input logic [255:0] l, input logic [2:0] sw, input int mode,
                         input bit offer, input logic [255:0] l_b, input int abort_after);
    logic [255:0] asm_line;
    logic [2:0]   ei;
    logic         wr;
    int           k;
    int           cyc;
    asm_line = '0;
    chk("idle_line_ready", {255'd0, line_ready}, 256'd1);
    chk("idle_word_valid", {255'd0, word_valid}, 256'd0);
    line_in    = l;
    start_word = sw;
    line_valid = 1'b1;
    word_ready = 1'b0;
    @(negedge clk);
    line_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      if (abort_after != 0 && k == abort_after) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_word_valid", {255'd0, word_valid}, 256'd0);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_line_ready", {255'd0, line_ready}, 256'd0);
        chk("abort_word_out", {224'd0, word_out}, 256'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        word_ready = 1'b0;
        #1;
        chk("release_line_ready", {255'd0, line_ready}, 256'd1);
        chk("release_word_valid", {255'd0, word_valid}, 256'd0);
        return;
      end
      ei = exp_idx(sw, k);
      chk("send_word_valid", {255'd0, word_valid}, 256'd1);
      chk("send_line_ready", {255'd0, line_ready}, 256'd0);
      chk("send_busy", {255'd0, busy}, 256'd1);
      chk("send_word_idx", {253'd0, word_idx}, {253'd0, ei});
      chk("send_word_out", {224'd0, word_out}, {224'd0, l[int'(ei)*32 +: 32]});
      chk("send_word_last", {255'd0, word_last}, {255'd0, (k == 7)});
      case (mode)
        0:       wr = 1'b1;
        1:       wr = (cyc % 3 == 0);
        default: wr = 1'($urandom_range(0, 1));
      endcase
      word_ready = wr;
      if (offer) begin
        line_in    = l_b;
        line_valid = 1'b1;
      end
      if (wr) asm_line[int'(word_idx)*32 +: 32] = word_out;
      @(negedge clk);
      cyc++;
      if (wr) k++;
    end
    word_ready = 1'b0;
    chk("burst_timeout", {255'd0, (cyc < 100)}, 256'd1);
    chk("end_word_valid", {255'd0, word_valid}, 256'd0);
    chk("end_line_ready", {255'd0, line_ready}, 256'd1);
    chk("end_busy", {255'd0, busy}, 256'd0);
    chk("round_trip", asm_line, l);
  endtask

  initial begin
    logic [255:0] l0;
    logic [255:0] lb;
    for (int i = 0; i < 8; i++) begin
      l0[i*32 +: 32] = 32'h1111_1111 * 32'(i);
      lb[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    rst        = 1'b1;
    line_in    = '0;
    line_valid = 1'b0;
    start_word = 3'd0;
    word_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line_ready", {255'd0, line_ready}, 256'd0);
    chk("rst_word_valid", {255'd0, word_valid}, 256'd0);
    chk("rst_word_out", {224'd0, word_out}, 256'd0);
    chk("rst_word_idx", {253'd0, word_idx}, 256'd0);
    chk("rst_word_last", {255'd0, word_last}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_line_ready", {255'd0, line_ready}, 256'd1);

    do_line(l0, 3'd0, 0, 1'b0, '0, 0);
    do_line(l0, 3'd0, 1, 1'b1, lb, 0);
    do_line(lb, 3'd0, 0, 1'b0, '0, 0);
    do_line(l0, 3'd0, 1, 1'b0, '0, 3);
    do_line(rand_line(), 3'd0, 0, 1'b0, '0, 0);
    do_line(rand_line(), 3'd5, 0, 1'b0, '0, 0);
    do_line(rand_line(), 3'd5, 1, 1'b0, '0, 0);
    for (int n = 0; n < 100; n++) begin
      do_line(rand_line(), 3'($urandom_range(0, 7)), 2, 1'b0, '0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
